// File: rtl/serial_subtractor.sv
// Multi-cycle two's-complement subtractor: Out = In1 - In2, computed DIGIT bits per
// clock LSB-first as In1 + ~In2 + 1, with start/busy/done handshake and borrow/overflow flags.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out,
  output logic             Borrow,
  output logic             Overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_subtractor: DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
  logic             cy_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_a_q, sign_b_q;
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             accept, last;

  // One digit of In1 + ~In2 + carry; the finished digit enters the result from the top.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    {dcout, dsum} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, ~b_q[DIGIT-1:0]} + (DIGIT + 1)'(cy_q);
    res_next      = WIDTH'({dsum, res_q} >> DIGIT);
    accept        = Start && (state_q != S_RUN);
    last          = (state_q == S_RUN) && (cnt_q == CW'(N - 1));
    state_d       = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  state_d = Start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the reset branch clears every register, including the operand and result
  // shift registers, so an abandoned op leaves no residue visible on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      Out      <= '0;
      Borrow   <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (accept) begin
        a_q      <= In1;
        b_q      <= In2;
        res_q    <= '0;
        cy_q     <= 1'b1;
        cnt_q    <= '0;
        sign_a_q <= In1[WIDTH-1];
        sign_b_q <= In2[WIDTH-1];
      end else if (state_q == S_RUN) begin
        a_q   <= a_q >> DIGIT;
        b_q   <= b_q >> DIGIT;
        res_q <= res_next;
        cy_q  <= dcout;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          Out      <= res_next;
          Borrow   <= ~dcout;
          Overflow <= (sign_a_q != sign_b_q) && (res_next[WIDTH-1] != sign_a_q);
        end
      end
    end
  end

  assign Busy = (state_q == S_RUN);
  assign Done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a DIGIT=1 and a DIGIT=8 instance checked every cycle
// against an arithmetic model, plus directed literal expectations.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st[2];
  logic [31:0] in1[2], in2[2];
  logic        busy[2], done[2], borrow[2], ovf[2];
  logic [31:0] out[2];

  int checks = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(32), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Start(st[0]), .In1(in1[0]), .In2(in2[0]),
    .Busy(busy[0]), .Done(done[0]), .Out(out[0]), .Borrow(borrow[0]), .Overflow(ovf[0])
  );

  serial_subtractor #(.WIDTH(32), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .Start(st[1]), .In1(in1[1]), .In2(in2[1]),
    .Busy(busy[1]), .Done(done[1]), .Out(out[1]), .Borrow(borrow[1]), .Overflow(ovf[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b);
    longint d;
    longint lim;
    lim = 64'sd2147483648;
    d   = longint'($signed(a)) - longint'($signed(b));
    return (d >= lim) || (d < -lim);
  endfunction

  // Model: an accepted op completes a fixed number of cycles later with the exact difference.
  localparam int ncyc[2] = '{32, 4};
  int          rem[2];
  logic [31:0] pa[2], pb[2], m_out[2];
  logic        m_borrow[2], m_ovf[2], m_done[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2; j++) begin
        rem[j] <= 0; pa[j] <= '0; pb[j] <= '0; m_out[j] <= '0;
        m_borrow[j] <= 1'b0; m_ovf[j] <= 1'b0; m_done[j] <= 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        m_done[j] <= 1'b0;
        if (rem[j] > 0) begin
          rem[j] <= rem[j] - 1;
          if (rem[j] == 1) begin
            m_out[j]    <= pa[j] - pb[j];
            m_borrow[j] <= (pa[j] < pb[j]);
            m_ovf[j]    <= sub_ovf(pa[j], pb[j]);
            m_done[j]   <= 1'b1;
          end
        end else if (st[j]) begin
          pa[j]  <= in1[j];
          pb[j]  <= in2[j];
          rem[j] <= ncyc[j];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      check($sformatf("cyc_busy%0d", j), busy[j], rem[j] > 0);
      check($sformatf("cyc_done%0d", j), done[j], m_done[j]);
      check($sformatf("cyc_out%0d", j), out[j], m_out[j]);
      check($sformatf("cyc_borrow%0d", j), borrow[j], m_borrow[j]);
      check($sformatf("cyc_ovf%0d", j), ovf[j], m_ovf[j]);
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eo,
                        input logic eb, input logic eov, input string tag);
    int n;
    st[0] = 1'b1; in1[0] = a; in2[0] = b;
    @(posedge clk); #1;
    st[0] = 1'b0; in1[0] = $urandom; in2[0] = $urandom;
    n = 0;
    while (!done[0] && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, n, 32);
    check({tag, "_out"}, out[0], eo);
    check({tag, "_borrow"}, borrow[0], eb);
    check({tag, "_ovf"}, ovf[0], eov);
  endtask

  initial begin
    int n, m, bc, dc;
    for (int j = 0; j < 2; j++) begin
      st[j] = 1'b0; in1[j] = '0; in2[j] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy[0], 1'b0);
    check("reset_done", done[0], 1'b0);
    check("reset_out", out[0], 32'h0);
    rst_n = 1'b1;

    run_op(32'd5, 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, "t1");
    run_op(-32'sd10, -32'sd5, 32'hFFFFFFFB, 1'b1, 1'b0, "t2");
    run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, "t3a");
    run_op(32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1, "t3b");

    // Start pulses while running must be ignored.
    st[0] = 1'b1; in1[0] = 32'd100; in2[0] = 32'd33;
    @(posedge clk); #1;
    st[0] = 1'b0;
    n = 0;
    bc = busy[0] ? 1 : 0;
    while (!done[0] && n < 100) begin
      st[0] = (n == 5 || n == 10);
      if (st[0]) begin in1[0] = n; in2[0] = 32'd1000; end
      @(posedge clk); #1; n++;
      if (busy[0]) bc++;
    end
    st[0] = 1'b0;
    check("t4_latency", n, 32);
    check("t4_busy_cycles", bc, 32);
    check("t4_out", out[0], 32'd67);
    dc = 0;
    repeat (40) begin @(posedge clk); #1; if (done[0]) dc++; end
    check("t4_extra_done", dc, 0);

    // Reset in the middle of an op.
    st[0] = 1'b1; in1[0] = 32'd50; in2[0] = 32'd8;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy[0], 1'b0);
    check("t5_done", done[0], 1'b0);
    check("t5_out", out[0], 32'h0);
    check("t5_borrow", borrow[0], 1'b0);
    check("t5_ovf", ovf[0], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dc = 0;
    repeat (40) begin @(posedge clk); #1; if (done[0]) dc++; end
    check("t5_no_done", dc, 0);
    run_op(32'd50, 32'd8, 32'd42, 1'b0, 1'b0, "t5");

    // DIGIT=8, Start held: back-to-back ops with Done every N+1 cycles.
    st[1] = 1'b1; in1[1] = 32'd9; in2[1] = 32'd3;
    @(posedge clk); #1;
    in1[1] = 32'd3; in2[1] = 32'd9;
    n = 0;
    while (!done[1] && n < 50) begin @(posedge clk); #1; n++; end
    check("t6_first_latency", n, 4);
    check("t6_first_out", out[1], 32'd6);
    check("t6_first_borrow", borrow[1], 1'b0);
    m = 0;
    do begin @(posedge clk); #1; m++; end while (!done[1] && m < 50);
    st[1] = 1'b0;
    check("t6_period", m, 5);
    check("t6_second_out", out[1], 32'hFFFFFFFA);
    check("t6_second_borrow", borrow[1], 1'b1);
    check("t6_second_ovf", ovf[1], 1'b0);

    repeat (12) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
